// File: rtl/bram_region_writer.sv
// bram_region_writer: streams 40-bit words into a W x H region of a
// row-major BRAM array (pitch = arraywidth words), one write per clk.
// Ports:
//   clk, rst (async, active-low)
//   start, base_addr, region_w, region_h, arraywidth, abort : control
//   in_data, in_valid, in_ready : input word stream (valid/ready)
//   MemAddr, MemDataIn, mode, RW : BRAM controller port (RW=0 writes)
//   busy, done, err, words_written : status
module bram_region_writer #(
   parameter int         ADDR_W    = 40,
   parameter int         DATA_W    = 40,
   parameter logic [1:0] WORD_MODE = 2'd0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [15:0]       region_w,
   input  logic [15:0]       region_h,
   input  logic [15:0]       arraywidth,
   input  logic              abort,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [DATA_W-1:0] MemDataIn,
   output logic [1:0]        mode,
   output logic              RW,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [31:0]       words_written
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t state, state_nx;

   logic [15:0]       wl;
   logic [15:0]       hl;
   logic [15:0]       pitch;
   logic [15:0]       col;
   logic [15:0]       row;
   logic [ADDR_W-1:0] row_base;

   logic hs;
   logic last_col;
   logic last_row;
   logic empty;
   logic go;
   logic bad;

   assign in_ready = (state == RUN);
   assign busy     = (state == RUN);
   assign mode     = WORD_MODE;

   // abort wins over a same-cycle handshake
   assign hs       = (state == RUN) & in_valid & ~abort;
   assign last_col = (col == wl - 16'd1);
   assign last_row = (row == hl - 16'd1);

   assign empty = start & ((region_w == 16'd0) | (region_h == 16'd0));
   assign go    = start & ~empty & (region_w <= arraywidth);
   assign bad   = start & ~empty & (region_w > arraywidth);

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (go) state_nx = RUN;
         end
         RUN: begin
            if (abort)
               state_nx = IDLE;
            else if (hs & last_col & last_row)
               state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wl            <= '0;
         hl            <= '0;
         pitch         <= '0;
         col           <= '0;
         row           <= '0;
         row_base      <= '0;
         MemAddr       <= '0;
         MemDataIn     <= '0;
         RW            <= 1'b1;
         done          <= 1'b0;
         err           <= 1'b0;
         words_written <= '0;
      end else begin
         RW   <= 1'b1;
         done <= 1'b0;
         err  <= 1'b0;
         if (state == IDLE) begin
            if (go) begin
               wl            <= region_w;
               hl            <= region_h;
               pitch         <= arraywidth;
               row_base      <= base_addr;
               col           <= '0;
               row           <= '0;
               words_written <= '0;
            end
            if (empty) done <= 1'b1;
            if (bad)   err  <= 1'b1;
         end else if (hs) begin
            // sums wrap naturally at ADDR_W bits
            MemAddr       <= row_base + ADDR_W'(col);
            MemDataIn     <= in_data;
            RW            <= 1'b0;
            words_written <= words_written + 32'd1;
            if (last_col) begin
               col      <= '0;
               row      <= row + 16'd1;
               row_base <= row_base + ADDR_W'(pitch);
               if (last_row) done <= 1'b1;
            end else begin
               col <= col + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_bram_region_writer.sv
// Bench for bram_region_writer: scoreboard of expected writes,
// popped as each write appears on the BRAM port.
module tb_bram_region_writer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [39:0] base_addr;
   logic [15:0] region_w;
   logic [15:0] region_h;
   logic [15:0] arraywidth;
   logic        abort;
   logic [39:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [39:0] MemAddr;
   logic [39:0] MemDataIn;
   logic [1:0]  mode;
   logic        RW;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] words_written;

   bram_region_writer dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .region_w(region_w), .region_h(region_h),
      .arraywidth(arraywidth), .abort(abort), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready), .MemAddr(MemAddr),
      .MemDataIn(MemDataIn), .mode(mode), .RW(RW), .busy(busy),
      .done(done), .err(err), .words_written(words_written)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   logic [79:0] q[$];
   int run = 0;
   int max_run = 0;
   int done_cnt = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (RW === 1'b0) begin
         run++;
         if (run > max_run) max_run = run;
         if (q.size() == 0) begin
            chk("unexp_wr", 64'(MemAddr), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            logic [79:0] e;
            e = q.pop_front();
            chk("addr", 64'(MemAddr), 64'(e[79:40]));
            chk("data", 64'(MemDataIn), 64'(e[39:0]));
         end
      end else begin
         run = 0;
      end
   end

   task automatic do_start(input logic [39:0] b, input logic [15:0] w,
                           input logic [15:0] h, input logic [15:0] aw);
      base_addr  = b;
      region_w   = w;
      region_h   = h;
      arraywidth = aw;
      start      = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // send one word; push expected write when handshake will occur
   task automatic send(input logic [39:0] a, input logic [39:0] d);
      int n;
      in_valid = 1'b1;
      in_data  = d;
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            q.push_back({a, d});
            @(posedge clk);
            #1;
            break;
         end
         n++;
         if (n > 50) begin
            chk("tmo", 64'd0, 64'd1);
            break;
         end
      end
   endtask

   // full region; gap inserts an idle cycle after each word
   task automatic region(input logic [39:0] b, input logic [15:0] w,
                         input logic [15:0] h, input logic [15:0] aw,
                         input bit gap, input logic [39:0] d0);
      logic [39:0] a;
      logic [39:0] d;
      int k;
      int dc;
      dc = done_cnt;
      max_run = 0;
      do_start(b, w, h, aw);
      k = 0;
      for (int r = 0; r < int'(h); r++) begin
         for (int c = 0; c < int'(w); c++) begin
            a = b + 40'(r) * 40'(aw) + 40'(c);
            d = d0 + 40'(k);
            k++;
            send(a, d);
            if (gap && k < int'(w) * int'(h)) begin
               in_valid = 1'b0;
               @(posedge clk);
               #1;
            end
         end
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("done_last", 64'(done), 64'd1);
      chk("busy_last", 64'(busy), 64'd0);
      chk("rdy_last", 64'(in_ready), 64'd0);
      chk("ww", 64'(words_written), 64'(k));
      @(negedge clk);
      chk("done_once", 64'(done_cnt - dc), 64'd1);
      chk("q_empty", 64'(q.size()), 64'd0);
   endtask

   initial begin
      rst = 1'b0;
      start = 1'b0;
      base_addr = '0;
      region_w = '0;
      region_h = '0;
      arraywidth = '0;
      abort = 1'b0;
      in_data = '0;
      in_valid = 1'b0;
      #12;
      chk("rst_rdy", 64'(in_ready), 64'd0);
      chk("rst_rw", 64'(RW), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ww", 64'(words_written), 64'd0);
      chk("rst_addr", 64'(MemAddr), 64'd0);
      chk("mode", 64'(mode), 64'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;

      // 1: back-to-back 4x2
      region(40'd0, 16'd4, 16'd2, 16'd64, 1'b0, 40'd1);
      chk("run8", 64'(max_run), 64'd8);

      // 2: valid toggling
      region(40'd0, 16'd4, 16'd2, 16'd64, 1'b1, 40'd1);
      chk("run1", 64'(max_run), 64'd1);

      // 3: address wrap
      region(40'hFF_FFFF_FFFE, 16'd4, 16'd1, 16'd16, 1'b0, 40'hA0);

      // 4: zero-size and oversize starts
      begin
         int dc;
         dc = done_cnt;
         do_start(40'd5, 16'd0, 16'd5, 16'd64);
         @(negedge clk);
         chk("zdone", 64'(done), 64'd1);
         chk("zrw", 64'(RW), 64'd1);
         chk("zbusy", 64'(busy), 64'd0);
         do_start(40'd5, 16'd65, 16'd2, 16'd64);
         @(negedge clk);
         chk("err", 64'(err), 64'd1);
         chk("ebusy", 64'(busy), 64'd0);
         chk("edone", 64'(done_cnt - dc), 64'd1);
         @(negedge clk);
         chk("err_once", 64'(err), 64'd0);
         chk("ebusy2", 64'(busy), 64'd0);
         @(posedge clk);
         #1;
      end

      // 5: abort after 10 handshakes
      begin
         int dc;
         dc = done_cnt;
         do_start(40'd100, 16'd8, 16'd8, 16'd32);
         for (int k = 0; k < 10; k++)
            send(40'd100 + 40'(k / 8) * 40'd32 + 40'(k % 8),
                 40'h50 + 40'(k));
         abort = 1'b1;
         in_data = 40'hDEAD;
         @(posedge clk);
         #1 abort = 1'b0;
         in_valid = 1'b0;
         @(negedge clk);
         chk("ab_rdy", 64'(in_ready), 64'd0);
         chk("ab_busy", 64'(busy), 64'd0);
         chk("ab_rw", 64'(RW), 64'd1);
         chk("ab_ww", 64'(words_written), 64'd10);
         chk("ab_done", 64'(done_cnt - dc), 64'd0);
         chk("ab_q", 64'(q.size()), 64'd0);
         @(posedge clk);
         #1;
         region(40'd7, 16'd2, 16'd1, 16'd2, 1'b0, 40'h77);
      end

      // 6: async reset mid-transfer
      do_start(40'd200, 16'd4, 16'd4, 16'd8);
      for (int k = 0; k < 3; k++)
         send(40'd200 + 40'(k), 40'h300 + 40'(k));
      #1 rst = 1'b0;
      #1;
      chk("ar_rdy", 64'(in_ready), 64'd0);
      chk("ar_busy", 64'(busy), 64'd0);
      chk("ar_rw", 64'(RW), 64'd1);
      chk("ar_addr", 64'(MemAddr), 64'd0);
      chk("ar_data", 64'(MemDataIn), 64'd0);
      chk("ar_ww", 64'(words_written), 64'd0);
      q.delete();
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("ar_idle", 64'(busy), 64'd0);
      chk("ar_q", 64'(q.size()), 64'd0);
      in_valid = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=0 exp=1");
      $fatal(1, "timeout");
   end

endmodule
